mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  CPU-side initiator for the 512x8 data RAM's MOV/MOC handshake. Takes one load/store request
//  per start pulse, drives ReadWrite/Address/OpCode/DataIn, pulses MOV and waits for MOC.
//  Doublewords are sequenced as two 32-bit transfers, tracked against the RAM's DMOC.
//  Sits between the control unit/MDR and the RAM. Only block that drives MOV.
// PARAMETERS
//  TIMEOUT_CYCLES  64  clks allowed from MOV rise to MOC seen high; on expiry -> error
//  MOV_LOW_CYCLES  1   min clks MOV held low between transfers (RAM triggers on posedge MOV)
//  SYNC_STAGES     2   flop stages on MOC and DMOC inputs (both are asynchronous to clk)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  start       in   1   request strobe; sampled only in IDLE
//  op          in   6   MIPS opcode: 110101 ld.d, 100011 lw, 100101 lhu, 100001 lh, 100100 lbu,
//                       100000 lb, 111111 sd.d, 101011 sw, 101001 sh, 101000 sb
//  addr        in   9   byte address
//  wdata_hi    in   32  store data (first half for sd.d; only word for sw/sh/sb)
//  wdata_lo    in   32  second half for sd.d; ignored otherwise
//  busy        out  1   high from start accept until done
//  done        out  1   1-clk pulse at request end (success or error)
//  err         out  1   valid with done: timeout, bad opcode, DMOC mismatch, misaligned
//  rdata_hi    out  32  ld.d first half; 0 for single loads
//  rdata_lo    out  32  ld.d second half or single-load result
//  mem_mov     out  1   MOV to RAM
//  mem_rw      out  1   1=read, 0=write
//  mem_addr    out  9   RAM Address
//  mem_op      out  6   RAM OpCode
//  mem_wdata   out  32  RAM DataIn
//  mem_rdata   in   32  RAM DataOut
//  mem_moc     in   1   RAM MOC
//  mem_dmoc    in   1   RAM DMOC
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE. A reset mid-op drops MOV at once and abandons the op.
//  Registers: op, addr, wdata latched on accepted start. mem_addr/mem_op/mem_rw stay constant for
//    the whole request. The RAM adds +4 for the second half, so mem_addr does not change.
//  FSM:
//   IDLE: start=1 with valid op -> SETUP, busy=1.
//     start=1 with invalid op -> DONE with err=1, MOV never raised.
//   SETUP: drive bus with MOV=0 for 1 clk.
//     For a doubleword first half, synced DMOC must be 0, else DONE with err=1.
//   PULSE: mem_mov=1; clear and start timeout counter -> WAIT_CLR.
//   WAIT_CLR: wait for synced MOC==0. This rejects the stale MOC=1 left from the prior access.
//   WAIT_SET: wait for synced MOC==1.
//     On a read, capture mem_rdata (first dw half -> rdata_hi, else rdata_lo).
//     Synced DMOC must be 1 after a dw first half and 0 after a second half, else err.
//     Then -> GAP.
//   GAP: mem_mov=0 for MOV_LOW_CYCLES. A pending second half -> SETUP; else -> DONE.
//   DONE: done=1 for 1 clk, busy=0 -> IDLE. err is held until the next start accept.
//  Timeout: the counter runs in WAIT_CLR/WAIT_SET. Reaching TIMEOUT_CYCLES -> MOV=0, then DONE
//    with err=1. No second half is issued.
//  Write data: mem_wdata=wdata_hi for single stores and the sd.d first half, wdata_lo for the second.
//  Reads: mem_wdata=0. Sign/zero extension is done by the RAM and passed through unmodified.
//  Latency with zero-delay MOC and SYNC_STAGES=2:
//    single access: 7 clks start->done; ld.d/sd.d: 12 clks.
//  start while busy: ignored. start in the DONE cycle: ignored.
//  Transfers never overlap: MOV never rises without a preceding low of MOV_LOW_CYCLES or more.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: at start accept, a misaligned addr goes to DONE with err=1 and MOV is
//    never raised. Misaligned means: dw needs addr[2:0]==0, word addr[1:0]==0, half addr[0]==0.
//  ALIGN_CHECK_EN undefined: no check. The address is passed unmodified and the RAM's own
//    write masking applies.
// TESTING
//  1 sw addr=0x010 wdata_hi=0xDEADBEEF, then lw addr=0x010 -> one MOV pulse each,
//    rdata_lo=0xDEADBEEF, err=0, done 7 clks after start.
//  2 sd.d addr=0x020 hi=0x11223344 lo=0x55667788, then ld.d addr=0x020 -> two MOV pulses each,
//    rdata_hi=0x11223344, rdata_lo=0x55667788, RAM DMOC back to 0.
//  3 lb addr=0x030 holding 0x80 -> rdata_lo=0xFFFFFF80; lbu -> 0x00000080.
//  4 Model holds MOC low, TIMEOUT_CYCLES=64 -> MOV drops, done with err=1 after 64 clks
//    in WAIT states.
//  5 reset asserted in WAIT_SET of a ld.d first half -> MOV=0 immediately.
//    The next ld.d sees DMOC=1 and gets err=1 with no MOV pulse.
//  6 op=6'b000000 -> err=1, no MOV. With ALIGN_CHECK_EN, sw addr=0x012 -> err=1, no MOV;
//    without it -> normal write.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose : CPU-side MOV/MOC initiator for the 512x8 data RAM; one load/store per start, doubleword as two 32-bit transfers tracked via DMOC.
// Latency : zero-delay MOC, SYNC_STAGES=2 -> single access 7 clks start->done, ld.d/sd.d 12 clks (the cycle start is presented counts as 1).
// Backpressure: start is sampled only in IDLE; start while busy or during the done cycle is dropped. Optional macro: ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MOV_LOW_CYCLES = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata_hi,
  input  logic [31:0] wdata_lo,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_hi,
  output logic [31:0] rdata_lo,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic [8:0]  mem_addr,
  output logic [5:0]  mem_op,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  input  logic        mem_dmoc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_WAIT_CLR = 3'd3;
  localparam logic [2:0] S_WAIT_SET = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int CW = 16;

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] moc_sync;
  logic [SYNC_STAGES-1:0] dmoc_sync;
  logic                   moc_s;
  logic                   dmoc_s;
  logic [CW-1:0]          cnt;
  logic                   is_dw;
  logic                   is_read;
  logic                   second;
  logic                   abort;
  logic [31:0]            wdata_lo_q;
  logic                   dec_valid;
  logic                   dec_read;
  logic [1:0]             dec_size;
  logic                   misaligned;
  logic                   tmo_last;
  logic                   gap_last;

  assign moc_s    = moc_sync[SYNC_STAGES-1];
  assign dmoc_s   = dmoc_sync[SYNC_STAGES-1];
  assign tmo_last = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign gap_last = (cnt == CW'(MOV_LOW_CYCLES - 1));
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

  // Opcode decode: size 3=doubleword, 2=word, 1=half, 0=byte.
  always_comb begin
    dec_valid = 1'b0;
    dec_read  = 1'b0;
    dec_size  = 2'd0;
    case (op)
      6'b110101: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd3; end
      6'b100011: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd2; end
      6'b100101: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd1; end
      6'b100001: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd1; end
      6'b100100: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd0; end
      6'b100000: begin dec_valid = 1'b1; dec_read = 1'b1; dec_size = 2'd0; end
      6'b111111: begin dec_valid = 1'b1; dec_size = 2'd3; end
      6'b101011: begin dec_valid = 1'b1; dec_size = 2'd2; end
      6'b101001: begin dec_valid = 1'b1; dec_size = 2'd1; end
      6'b101000: begin dec_valid = 1'b1; dec_size = 2'd0; end
      default:   begin dec_valid = 1'b0; end
    endcase
  end

`ifdef ALIGN_CHECK_EN
  // Natural alignment for the access size, checked at start accept.
  always_comb begin
    misaligned = 1'b0;
    case (dec_size)
      2'd3:    misaligned = (addr[2:0] != 3'd0);
      2'd2:    misaligned = (addr[1:0] != 2'd0);
      2'd1:    misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // MOC and DMOC come from the RAM's own timing domain; resynchronise both identically.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moc_sync  <= '0;
      dmoc_sync <= '0;
    end else begin
      moc_sync  <= {moc_sync[SYNC_STAGES-2:0], mem_moc};
      dmoc_sync <= {dmoc_sync[SYNC_STAGES-2:0], mem_dmoc};
    end
  end

  // Request sequencer: bus setup, MOV pulse, MOC handshake, low gap, doubleword second half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_dw      <= 1'b0;
      is_read    <= 1'b0;
      second     <= 1'b0;
      abort      <= 1'b0;
      wdata_lo_q <= '0;
      err        <= 1'b0;
      rdata_hi   <= '0;
      rdata_lo   <= '0;
      mem_mov    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_op     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err        <= 1'b0;
            rdata_hi   <= '0;
            rdata_lo   <= '0;
            mem_op     <= op;
            mem_addr   <= addr;
            mem_rw     <= dec_read;
            mem_wdata  <= dec_read ? 32'd0 : wdata_hi;
            wdata_lo_q <= wdata_lo;
            is_dw      <= dec_valid && (dec_size == 2'd3);
            is_read    <= dec_read;
            second     <= 1'b0;
            abort      <= 1'b0;
            if (!dec_valid || misaligned) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          // A doubleword must start with the RAM's half tracker cleared.
          if (is_dw && !second && dmoc_s) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            mem_mov <= 1'b1;
            cnt     <= '0;
            state   <= S_PULSE;
          end
        end
        S_PULSE: begin
          cnt   <= '0;
          state <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          // Let the previous access's MOC fall before trusting a high level.
          if (!moc_s) begin
            cnt   <= cnt + 1'b1;
            state <= S_WAIT_SET;
          end else if (tmo_last) begin
            mem_mov <= 1'b0;
            err     <= 1'b1;
            abort   <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_SET: begin
          if (moc_s) begin
            if (is_read) begin
              if (is_dw && !second) rdata_hi <= mem_rdata;
              else                  rdata_lo <= mem_rdata;
            end
            if (is_dw && (dmoc_s == second)) begin
              err   <= 1'b1;
              abort <= 1'b1;
            end
            mem_mov <= 1'b0;
            cnt     <= '0;
            state   <= S_GAP;
          end else if (tmo_last) begin
            mem_mov <= 1'b0;
            err     <= 1'b1;
            abort   <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            cnt <= '0;
            if (is_dw && !second && !abort) begin
              second    <= 1'b1;
              mem_wdata <= is_read ? 32'd0 : wdata_lo_q;
              state     <= S_SETUP;
            end else begin
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural 512x8 RAM with MOV/MOC/DMOC handshake plus a byte-array reference model.
// Latency figures below count sampling edges after start is presented (the 7/12-clock figures include the start cycle).
// Randomised traffic compares load results against the reference; directed tasks cover timeout, reset, bad op and alignment.
module tb_mem_access_ctrl;

  localparam logic [5:0] LDD = 6'b110101, LW = 6'b100011, LHU = 6'b100101, LH = 6'b100001;
  localparam logic [5:0] LBU = 6'b100100, LB = 6'b100000, SDD = 6'b111111, SW = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001, SB = 6'b101000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = '0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata_hi = '0, wdata_lo = '0;
  logic        busy, done, err;
  logic [31:0] rdata_hi, rdata_lo;
  logic        mem_mov, mem_rw;
  logic [8:0]  mem_addr;
  logic [5:0]  mem_op;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_moc;
  logic        mem_dmoc;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
    .wdata_hi(wdata_hi), .wdata_lo(wdata_lo), .busy(busy), .done(done), .err(err),
    .rdata_hi(rdata_hi), .rdata_lo(rdata_lo), .mem_mov(mem_mov), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_op(mem_op), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_moc(mem_moc), .mem_dmoc(mem_dmoc)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  logic [7:0] ram_mem [512];
  logic       ram_dmoc = 1'b0;
  logic       moc_flag = 1'b0;
  logic       moc_hold = 1'b0;
  logic       ram_clr = 1'b0;
  int         moc_delay = 0;
  int         pulses = 0;
  logic [8:0] ram_a;
  logic       ram_dw;

  assign mem_moc  = moc_flag & mem_mov;
  assign mem_dmoc = ram_dmoc;

  function automatic logic [31:0] ram_read(input logic [5:0] o, input logic [8:0] a);
    logic [31:0] w;
    w = {ram_mem[a], ram_mem[9'(a + 1)], ram_mem[9'(a + 2)], ram_mem[9'(a + 3)]};
    case (o)
      LW, LDD: return w;
      LH:      return {{16{w[31]}}, w[31:16]};
      LHU:     return {16'd0, w[31:16]};
      LB:      return {{24{w[31]}}, w[31:24]};
      LBU:     return {24'd0, w[31:24]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge mem_mov or posedge ram_clr) begin
    if (ram_clr) begin
      ram_dmoc = 1'b0;
    end else begin
      pulses++;
      moc_flag = 1'b0;
      if (!moc_hold) begin
        ram_dw = (mem_op == LDD) || (mem_op == SDD);
        ram_a  = (ram_dw && ram_dmoc) ? 9'(mem_addr + 9'd4) : mem_addr;
        if (mem_rw) begin
          mem_rdata = ram_read(mem_op, ram_a);
        end else begin
          case (mem_op)
            SW, SDD: begin
              ram_mem[ram_a] = mem_wdata[31:24]; ram_mem[9'(ram_a + 1)] = mem_wdata[23:16];
              ram_mem[9'(ram_a + 2)] = mem_wdata[15:8]; ram_mem[9'(ram_a + 3)] = mem_wdata[7:0];
            end
            SH: begin ram_mem[ram_a] = mem_wdata[15:8]; ram_mem[9'(ram_a + 1)] = mem_wdata[7:0]; end
            SB: ram_mem[ram_a] = mem_wdata[7:0];
            default: ;
          endcase
        end
        if (moc_delay > 0) repeat (moc_delay) @(posedge clk);
        if (mem_mov) begin
          if (ram_dw) ram_dmoc = ~ram_dmoc;
          moc_flag = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model (flat byte array) ----------------
  logic [7:0] ref_mem [512];

  function automatic int op_bytes(input logic [5:0] o);
    case (o)
      LDD, SDD: return 8;
      LW, SW: return 4;
      LH, LHU, SH: return 2;
      LB, LBU, SB: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic ref_req(input logic [5:0] o, input logic [8:0] a, input logic [31:0] h,
                         input logic [31:0] l, output logic [31:0] eh, output logic [31:0] el);
    int n;
    logic [63:0] v;
    logic st, sgn;
    n   = op_bytes(o);
    st  = (o == SDD) || (o == SW) || (o == SH) || (o == SB);
    sgn = (o == LH) || (o == LB);
    eh = 32'd0;
    el = 32'd0;
    if (n == 0) return;
    if (st) begin
      v = (n == 8) ? {h, l} : {32'd0, h};
      for (int i = 0; i < n; i++) ref_mem[9'(a + i)] = v[8*(n-1-i) +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = {v[55:0], ref_mem[9'(a + i)]};
      if (n == 8) begin
        {eh, el} = v;
      end else begin
        if (sgn && v[8*n-1]) v = v | (~64'd0 << (8*n));
        el = v[31:0];
      end
    end
  endtask

  // ---------------- request driver ----------------
  task automatic run_req(input logic [5:0] o, input logic [8:0] a, input logic [31:0] h,
                         input logic [31:0] l, output int lat, output int np, output int movc,
                         output logic e, output logic [31:0] rh, output logic [31:0] rl,
                         output logic bsy);
    int p0;
    @(posedge clk); #1;
    op = o; addr = a; wdata_hi = h; wdata_lo = l; start = 1'b1;
    p0 = pulses;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bsy = busy;
    movc = mem_mov ? 1 : 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (mem_mov === 1'b1) movc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_wait: done=%b after %0d clks, required 1", done, lat);
    end
    e = err; rh = rdata_hi; rl = rdata_lo;
    np = pulses - p0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, mem_mov, mem_rw} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/err/mov/rw=%b required 00000", {busy, done, err, mem_mov, mem_rw});
    end
    checks++;
    if ({rdata_hi, rdata_lo, mem_addr, mem_op, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: rh=%h rl=%h a=%h op=%h wd=%h required all 0", rdata_hi, rdata_lo, mem_addr, mem_op, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int lat, np, mc; logic e, b; logic [31:0] rh, rl, eh, el;
    run_req(SW, 9'h010, 32'hDEADBEEF, 32'h0, lat, np, mc, e, rh, rl, b);
    ref_req(SW, 9'h010, 32'hDEADBEEF, 32'h0, eh, el);
    checks++;
    if (e !== 1'b0 || np != 1 || lat != 6 || b !== 1'b1) begin
      failures++;
      $display("FAIL sw_single: err=%b pulses=%0d lat=%0d busy=%b required 0/1/6/1", e, np, lat, b);
    end
    run_req(LW, 9'h010, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b0 || np != 1 || lat != 6) begin
      failures++;
      $display("FAIL lw_single: err=%b pulses=%0d lat=%0d required 0/1/6", e, np, lat);
    end
    checks++;
    if (rl !== 32'hDEADBEEF || rh !== 32'h0) begin
      failures++;
      $display("FAIL lw_data: hi=%h lo=%h required 00000000 deadbeef", rh, rl);
    end
  endtask

  task automatic test_dword();
    int lat, np, mc; logic e, b; logic [31:0] rh, rl, eh, el;
    run_req(SDD, 9'h020, 32'h11223344, 32'h55667788, lat, np, mc, e, rh, rl, b);
    ref_req(SDD, 9'h020, 32'h11223344, 32'h55667788, eh, el);
    checks++;
    if (e !== 1'b0 || np != 2 || lat != 11) begin
      failures++;
      $display("FAIL sdd: err=%b pulses=%0d lat=%0d required 0/2/11", e, np, lat);
    end
    run_req(LDD, 9'h020, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b0 || np != 2 || lat != 11 || mem_dmoc !== 1'b0) begin
      failures++;
      $display("FAIL ldd: err=%b pulses=%0d lat=%0d dmoc=%b required 0/2/11/0", e, np, lat, mem_dmoc);
    end
    checks++;
    if (rh !== 32'h11223344 || rl !== 32'h55667788) begin
      failures++;
      $display("FAIL ldd_data: hi=%h lo=%h required 11223344 55667788", rh, rl);
    end
  endtask

  task automatic test_signext();
    int lat, np, mc; logic e, b; logic [31:0] rh, rl, eh, el;
    run_req(SB, 9'h030, 32'h00000080, 32'h0, lat, np, mc, e, rh, rl, b);
    ref_req(SB, 9'h030, 32'h00000080, 32'h0, eh, el);
    run_req(LB, 9'h030, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (rl !== 32'hFFFFFF80 || e !== 1'b0) begin
      failures++;
      $display("FAIL lb_sext: lo=%h err=%b required ffffff80/0", rl, e);
    end
    run_req(LBU, 9'h030, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (rl !== 32'h00000080 || e !== 1'b0) begin
      failures++;
      $display("FAIL lbu_zext: lo=%h err=%b required 00000080/0", rl, e);
    end
  endtask

  task automatic test_bad_op();
    int lat, np, mc; logic e, b; logic [31:0] rh, rl, eh, el;
    run_req(6'b000000, 9'h010, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b1 || np != 0 || lat != 1) begin
      failures++;
      $display("FAIL bad_op: err=%b pulses=%0d lat=%0d required 1/0/1", e, np, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_hold: done=%b err=%b required 0/1", done, err);
    end
    run_req(SW, 9'h012, 32'hCAFEF00D, 32'h0, lat, np, mc, e, rh, rl, b);
`ifdef ALIGN_CHECK_EN
    checks++;
    if (e !== 1'b1 || np != 0 || lat != 1) begin
      failures++;
      $display("FAIL misalign: err=%b pulses=%0d lat=%0d required 1/0/1", e, np, lat);
    end
`else
    ref_req(SW, 9'h012, 32'hCAFEF00D, 32'h0, eh, el);
    checks++;
    if (e !== 1'b0 || np != 1) begin
      failures++;
      $display("FAIL unaligned_sw: err=%b pulses=%0d required 0/1", e, np);
    end
    run_req(LW, 9'h012, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    ref_req(LW, 9'h012, 32'h0, 32'h0, eh, el);
    checks++;
    if (rl !== el || e !== 1'b0) begin
      failures++;
      $display("FAIL unaligned_lw: lo=%h err=%b required %h/0", rl, e, el);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    int lat, np, mc, n; logic e, b; logic [31:0] rh, rl, eh, el, h, l;
    logic [5:0] o; logic [8:0] a;
    ops = '{LDD, LW, LHU, LH, LBU, LB, SDD, SW, SH, SB};
    for (int t = 0; t < 40; t++) begin
      o = ops[$urandom_range(0, 9)];
      n = op_bytes(o);
      a = 9'($urandom) & ~9'(n - 1);
      h = $urandom; l = $urandom;
      moc_delay = $urandom_range(0, 3);
      run_req(o, a, h, l, lat, np, mc, e, rh, rl, b);
      ref_req(o, a, h, l, eh, el);
      checks++;
      if (e !== 1'b0 || np != ((n == 8) ? 2 : 1)) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: op=%b err=%b pulses=%0d required 0/%0d", t, o, e, np, (n == 8) ? 2 : 1);
      end
      checks++;
      if (rh !== eh || rl !== el) begin
        failures++;
        $display("FAIL rand_data[%0d]: op=%b a=%h got %h_%h required %h_%h", t, o, a, rh, rl, eh, el);
      end
    end
    moc_delay = 0;
  endtask

  task automatic test_timeout();
    int lat, np, mc; logic e, b; logic [31:0] rh, rl;
    moc_hold = 1'b1;
    run_req(LW, 9'h010, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b1 || np != 1 || lat != 68 || mc != 65 || mem_mov !== 1'b0) begin
      failures++;
      $display("FAIL timeout_lw: err=%b pulses=%0d lat=%0d movclks=%0d mov=%b required 1/1/68/65/0", e, np, lat, mc, mem_mov);
    end
    run_req(SDD, 9'h040, 32'h1, 32'h2, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b1 || np != 1) begin
      failures++;
      $display("FAIL timeout_sdd: err=%b pulses=%0d required 1/1", e, np);
    end
    moc_hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, lat, np, mc; logic e, b; logic [31:0] rh, rl;
    moc_delay = 3;
    @(posedge clk); #1;
    op = LDD; addr = 9'h020; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (mem_moc !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (mem_moc !== 1'b1) begin
      failures++;
      $display("FAIL moc_wait: moc=%b required 1", mem_moc);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_mov !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: mov=%b busy=%b required 0/0", mem_mov, busy);
    end
    #1 reset = 1'b0;
    moc_delay = 0;
    repeat (4) @(posedge clk);
    run_req(LDD, 9'h020, 32'h0, 32'h0, lat, np, mc, e, rh, rl, b);
    checks++;
    if (e !== 1'b1 || np != 0 || lat != 2) begin
      failures++;
      $display("FAIL stale_dmoc: err=%b pulses=%0d lat=%0d required 1/0/2", e, np, lat);
    end
    ram_clr = 1'b1;
    #1 ram_clr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int p0, dn;
    dn = 0;
    @(posedge clk); #1;
    p0 = pulses;
    op = LW; addr = 9'h010; start = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 1 || (pulses - p0) != 1) begin
      failures++;
      $display("FAIL back_to_back: done_pulses=%0d mov_pulses=%0d required 1/1", dn, pulses - p0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_single();
    test_dword();
    test_signext();
    test_bad_op();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
